dmem_access_arbiter: RTL

//  Two-port round-robin arbiter and access sequencer in front of the byte-addressed,
//  big-endian 32-bit data memory. Port 0 is the pipeline MEM stage; port 1 is the

---
 rtl/dmem_access_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_access_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the
// big-endian 32-bit data memory.
module dmem_access_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_READ, S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_rr;
  logic              r_port;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [2:0]        r_cnt;

  logic              w_any;
  logic              w_gnt;
  logic              w_gwe;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gwdata;
  logic              w_misal;
  logic              w_rd_last;

  // With both ports asking, r_rr decides; otherwise the lone requester wins.
  assign w_any    = m0_req | m1_req;
  assign w_gnt    = (m0_req & m1_req) ? r_rr : m1_req;
  assign w_gwe    = w_gnt ? m1_we    : m0_we;
  assign w_gaddr  = w_gnt ? m1_addr  : m0_addr;
  assign w_gwdata = w_gnt ? m1_wdata : m0_wdata;
  assign w_misal  = (ALIGN_CHECK != 0) && (w_gaddr[1:0] != 2'b00);
  assign w_rd_last = (r_cnt == 3'(RD_LAT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_misal)    w_next = S_RESP;
          else if (w_gwe) w_next = S_WRITE;
          else            w_next = S_READ;
        end
      end
      S_WRITE: w_next = S_RESP;
      S_READ:  if (w_rd_last) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr     <= 1'b0;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_rr    <= ~w_gnt;
            r_port  <= w_gnt;
            r_we    <= w_gwe;
            r_err   <= w_misal;
            r_addr  <= w_gaddr;
            r_wdata <= w_gwdata;
            r_cnt   <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_rd_last) begin
            if (r_port) r_rdata1 <= mem_rd_data;
            else        r_rdata0 <= mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Enables are gated by reset so an abort never reaches the memory.
  assign mem_wr_en   = (r_state == S_WRITE) && !reset;
  assign mem_wr_addr = r_addr;
  assign mem_wr_data = r_wdata;
  assign mem_rd_en   = (r_state == S_READ) && !reset;
  assign mem_rd_addr = r_addr;

  assign m0_done  = (r_state == S_RESP) && !r_port;
  assign m1_done  = (r_state == S_RESP) &&  r_port;
  assign m0_err   = m0_done && r_err;
  assign m1_err   = m1_done && r_err;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;
  assign busy     = (r_state != S_IDLE);

endmodule
